// File: rtl/pipeline_hazard_scoreboard.sv
// Hazard scoreboard for the in-order core. It tracks the writers in flight
// after ID (slot 0 = EXE ... slot STAGES-1 = WB). It raises a combinational
// stall for the ID instruction, registers per-source forwarding selects that
// line up with that instruction in EXE, and counts stall cycles.
module pipeline_hazard_scoreboard #(
    parameter int STAGES  = 3,
    parameter int REG_AW  = 4,
    parameter int NUM_SRC = 2,
    parameter int SEL_W   = 2,
    parameter int CNT_W   = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_forwarding_en,
    input  logic                      i_freeze,
    input  logic                      i_flush,
    input  logic                      i_issue_valid,
    input  logic                      i_issue_wb_en,
    input  logic                      i_issue_mem_read,
    input  logic [REG_AW-1:0]         i_issue_dest,
    input  logic [NUM_SRC*REG_AW-1:0] i_src_addr,
    input  logic [NUM_SRC-1:0]        i_src_used,
    output logic                      o_hazard_detected,
    output logic [NUM_SRC*SEL_W-1:0]  o_fwd_sel,
    output logic [CNT_W-1:0]          o_stall_count
);

    // In-flight writer slots, index 0 = EXE (youngest).
    logic              r_vld_pipe [STAGES];
    logic              r_wb_en    [STAGES];
    logic              r_mem_rd   [STAGES];
    logic [REG_AW-1:0] r_dest     [STAGES];

    logic [NUM_SRC-1:0][SEL_W-1:0] r_fwd_sel;
    logic [CNT_W-1:0]              r_stall_count;

    // Match matrix only covers EXE..MEM. The WB slot never causes a stall and
    // is never a forwarding source, because the register file already holds
    // its value by the time ID reads.
    logic [NUM_SRC-1:0][STAGES-2:0] w_wr;
    logic [NUM_SRC-1:0]             w_raw;
    logic [NUM_SRC-1:0][SEL_W-1:0]  w_sel;
    logic                           w_hazard;
    logic                           w_load;

    // Per-source writer match, RAW detection and youngest-writer forward select.
    always_comb begin
        w_wr  = '0;
        w_raw = '0;
        w_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = 0; k < STAGES-1; k++) begin
                w_wr[i][k] = r_vld_pipe[k] & r_wb_en[k] &
                             (r_dest[k] == i_src_addr[i*REG_AW +: REG_AW]);
            end
            if (i_src_used[i]) begin
                if (i_forwarding_en) begin
                    // With forwarding only a load still in EXE cannot be bypassed.
                    w_raw[i] = w_wr[i][0] & r_mem_rd[0];
                    // Walk oldest to youngest so the youngest match wins.
                    for (int k = STAGES-2; k >= 0; k--) begin
                        if (w_wr[i][k]) w_sel[i] = SEL_W'(k + 1);
                    end
                end else begin
                    w_raw[i] = |w_wr[i];
                end
            end
        end
        w_hazard = (|w_raw) & i_issue_valid & ~i_flush;
        w_load   = i_issue_valid & ~w_hazard & ~i_flush;
    end

    assign o_hazard_detected = w_hazard;
    assign o_fwd_sel         = r_fwd_sel;
    assign o_stall_count     = r_stall_count;

    // Shift the writer slots on every unfrozen edge; stalled or flushed ID inserts a bubble.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_vld_pipe[k] <= 1'b0;
                r_wb_en[k]    <= 1'b0;
                r_mem_rd[k]   <= 1'b0;
                r_dest[k]     <= '0;
            end
        end else if (!i_freeze) begin
            for (int k = STAGES-1; k >= 1; k--) begin
                r_vld_pipe[k] <= r_vld_pipe[k-1];
                r_wb_en[k]    <= r_wb_en[k-1];
                r_mem_rd[k]   <= r_mem_rd[k-1];
                r_dest[k]     <= r_dest[k-1];
            end
            r_vld_pipe[0] <= w_load;
            r_wb_en[0]    <= i_issue_wb_en;
            r_mem_rd[0]   <= i_issue_mem_read;
            r_dest[0]     <= i_issue_dest;
        end
    end

    // Forward selects follow the instruction into EXE; the stall counter saturates.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fwd_sel     <= '0;
            r_stall_count <= '0;
        end else if (!i_freeze) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                r_fwd_sel[i] <= w_load ? w_sel[i] : '0;
            end
            if (w_hazard && !(&r_stall_count)) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
        end
    end

endmodule
